window_gen_5x5: RTL and testbench
=================================

// Module: window_gen_5x5
// PURPOSE
// - Streaming 5x5 window generator that feeds the Gabor convolution blocks (0/45/90/180 variants).
// - Accepts raster-order pixels, buffers 4 image lines and emits one full 25-pixel window per valid position.
// - Valid-mode windowing: no border padding.
// - Output pixel1..pixel25 maps directly onto the convolution block pixel ports.
// PARAMETERS
// - pixel_int_width  9    integer bits of signed pixel
// - pixel_dec_width  0    fractional bits of pixel
// - img_width        516  pixels per line (BRAM_width)
// - img_height       516  lines per frame (img_width*img_height = BRAM_height)
// - kernel_size      5    window edge; only 5 is supported, elaboration error otherwise
// PORTS
// - clk         in   1       rising-edge clock
// - rst         in   1       synchronous, active-high reset
// - in_pixel    in   PW      signed pixel, PW = pixel_int_width+pixel_dec_width
// - in_valid    in   1       in_pixel valid
// - in_ready    out  1       block accepts in_pixel this cycle
// - win_pixels  out  25*PW   pixel k (1..25) at bits [k*PW-1 -: PW], row-major, pixel1 = top-left
// - out_valid   out  1       win_pixels/out_row/out_col valid
// - out_ready   in   1       downstream accepts window
// - out_row     out  clog2(img_height)  row of window centre
// - out_col     out  clog2(img_width)   column of window centre
// - frame_done  out  1       one-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
// - Reset: out_valid=0, frame_done=0, win_pixels=0, out_row=0, out_col=0; col/row counters=0; in_ready=1 the cycle after rst deasserts.
// - Line buffer contents are not cleared by reset; windows are gated by counters, so stale data is never emitted.
// - Global advance: en = !out_valid || out_ready; in_ready = en.
//   - A pixel is accepted on in_valid && en.
//   - Both pipeline stages move only when en=1.
//   - A stalled window holds all outputs stable.
// - Counters col (0..img_width-1) and row (0..img_height-1) increment per accepted pixel.
//   - col wraps to 0 with row++.
//   - At (img_height-1, img_width-1): both wrap to 0 and frame_done pulses on the next cycle.
// - Stage 1 (accept cycle):
//   - 4 line buffers are read at address col (1-cycle synchronous read).
//   - in_pixel is written to buffer 0 at col.
//   - Each buffer i's old value at col is written into buffer i+1 (cascade).
// - Stage 2:
//   - The 5x5 register window shifts left one column.
//   - New right column = {lb3, lb2, lb1, lb0, in_pixel}, top to bottom.
// - Emit rule: out_valid=1 two enabled cycles after accepting pixel (r,c) iff r>=4 && c>=4.
//   - The emitted window has bottom-right (r,c) and centre out_row=r-2, out_col=c-2.
// - Latency: 2 cycles with out_ready held high. Throughput: 1 window/cycle.
// - Windows per frame: (img_width-4)*(img_height-4). Positions with c<4 or r<4 are consumed with out_valid=0.
// - Simultaneous out_ready && in_valid with out_valid=1: the old window transfers and the new pixel is accepted in the same cycle.
// - in_valid=0 bubbles: counters hold and out_valid drops once the pending window is taken.
// - Mid-operation rst: pipeline is flushed, counters return to 0, and the next accepted pixel is treated as (0,0) of a new frame.
// - Arithmetic: none. Pixels pass bit-exact, signed, unmodified.
// STRUCTURE
// - gabor_pkg:
//   - localparam PW
//   - typedef logic signed [PW-1:0] pixel_t
//   - typedef pixel_t window_t [25]
//   - KERNEL_SIZE=5
//   - symmetry-group index lists (180: {1,5,6,10,11,15,16,20,21,25}, {2,4,7,9,12,14,17,19,22,24}, {3,8,13,18,23}) shared with the convolution blocks
// - Sub-module line_buffer:
//   - Simple dual-port memory, depth img_width, width PW, registered read, BRAM-inferable.
//   - 4 instances.
// - Top-level logic: counters, enable, 5x5 shift register, emit-gating.
// TESTING (img_width=8, img_height=6 unless noted; in_pixel = r*16+c)
// - Ramp, out_ready=1, in_valid=1:
//   - exactly 8 windows, first at centre (2,2).
//   - first window pixel1=0x00, pixel13=0x22, pixel25=0x44.
//   - first out_valid exactly 2 cycles after accepting pixel (4,4).
// - Backpressure, out_ready=0 for 5 cycles at window 3:
//   - in_ready=0 and win_pixels stable throughout.
//   - after release, windows 3..8 follow in order with none lost or duplicated.
// - Random in_valid (50%) and out_ready (50%):
//   - window sequence matches the scoreboard model.
//   - frame_done pulses once per 48 accepted pixels.
// - Two back-to-back frames, frame 2 pixel = -(r*16+c):
//   - frame 2 windows contain no frame 1 values.
//   - first frame 2 centre is (2,2), pixel1=0.
// - rst asserted after 20 pixels:
//   - out_valid=0 and frame_done=0 the next cycle.
//   - a full frame after rst yields the same output as the ramp test.
// - Signed extremes, pixel alternating -256/255, default 516x516 frame:
//   - 512*512 windows emitted.
//   - pixel13 equals the input at the centre coordinate, bit-exact.

Source files
------------

// File: rtl/gabor_pkg.sv
// Shared types and constants for the 5x5 window generator and the Gabor convolution blocks.
package gabor_pkg;

    localparam int PW          = 9;
    localparam int KERNEL_SIZE = 5;
    localparam int WIN_SIZE    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NUM_LB      = KERNEL_SIZE - 1;

    typedef logic signed [PW-1:0] pixel_t;
    typedef pixel_t window_t [WIN_SIZE];

    // Pixel indices (1-based, row-major) that share a coefficient in the 180-degree kernel.
    localparam int SYM180_OUTER [10] = '{1, 5, 6, 10, 11, 15, 16, 20, 21, 25};
    localparam int SYM180_INNER [10] = '{2, 4, 7, 9, 12, 14, 17, 19, 22, 24};
    localparam int SYM180_MID   [5]  = '{3, 8, 13, 18, 23};

    // Flat row-major window index (0-based) for window row r, column c.
    function automatic int win_index(input int r, input int c);
        return r * KERNEL_SIZE + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: simple dual-port RAM with registered read.
module line_buffer #(
    parameter int depth      = 516,
    parameter int width      = 9,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [width-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [width-1:0]      rd_data
);

    logic [width-1:0] mem [depth];

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; data holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 valid-mode window generator: raster pixels in, one 25-pixel window per valid position out.
module window_gen_5x5
    import gabor_pkg::*;
#(
    parameter int pixel_int_width = 9,
    parameter int pixel_dec_width = 0,
    parameter int img_width       = 516,
    parameter int img_height      = 516,
    parameter int kernel_size     = 5,
    localparam int PIX_W = pixel_int_width + pixel_dec_width,
    localparam int CW    = $clog2(img_width),
    localparam int RW    = $clog2(img_height)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [PIX_W-1:0]     in_pixel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIN_SIZE*PIX_W-1:0]   win_pixels,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RW-1:0]               out_row,
    output logic [CW-1:0]               out_col,
    output logic                        frame_done
);

    if (kernel_size != KERNEL_SIZE) begin : g_bad_kernel
        $error("window_gen_5x5 supports kernel_size = 5 only");
    end

    localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

    logic                    en;
    logic                    accept;
    logic                    last_col;
    logic                    last_row;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;

    logic                    v1;
    logic signed [PIX_W-1:0] pix1;
    logic [CW-1:0]           col1;
    logic [RW-1:0]           row1;

    logic [PIX_W-1:0]        lb_rdata [NUM_LB];
    logic [PIX_W-1:0]        lb_wdata [NUM_LB];
    logic                    lb_wr_en;
    logic                    lb_rd_en;

    logic signed [PIX_W-1:0] new_col [KERNEL_SIZE];
    logic signed [PIX_W-1:0] win [WIN_SIZE];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // Reads happen on accept; the cascade write lands one stage later at the same column,
    // so a read and a write never target the same address in one cycle.
    assign lb_rd_en = accept && !rst;
    assign lb_wr_en = en && v1 && !rst;

    // Raster position of the next pixel and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Stage 1: hold the accepted pixel and its coordinate alongside the line-buffer read.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            pix1 <= '0;
            col1 <= '0;
            row1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                pix1 <= in_pixel;
                col1 <= col;
                row1 <= row;
            end
        end
    end

    // Buffer 0 takes the new pixel; buffer i+1 takes buffer i's old value (line cascade).
    always_comb begin
        lb_wdata[0] = pix1;
        for (int i = 1; i < NUM_LB; i++) begin
            lb_wdata[i] = lb_rdata[i-1];
        end
    end

    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        line_buffer #(
            .depth (img_width),
            .width (PIX_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (lb_wr_en),
            .wr_addr (col1),
            .wr_data (lb_wdata[i]),
            .rd_en   (lb_rd_en),
            .rd_addr (col),
            .rd_data (lb_rdata[i])
        );
    end

    // Incoming right-hand column, oldest line at the top.
    always_comb begin
        for (int i = 0; i < NUM_LB; i++) begin
            new_col[i] = $signed(lb_rdata[NUM_LB-1-i]);
        end
        new_col[KERNEL_SIZE-1] = pix1;
    end

    // Stage 2: shift the window left and gate emission on the bottom-right coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                win[k] <= '0;
            end
        end else if (en) begin
            if (v1) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        win[win_index(r, c)] <= win[win_index(r, c + 1)];
                    end
                    win[win_index(r, KERNEL_SIZE - 1)] <= new_col[r];
                end
                out_valid <= (row1 >= RW'(NUM_LB)) && (col1 >= CW'(NUM_LB));
                out_row   <= row1 - RW'(2);
                out_col   <= col1 - CW'(2);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Flatten the window: pixel k (1..25) sits at bits [k*PIX_W-1 -: PIX_W].
    always_comb begin
        win_pixels = '0;
        for (int k = 0; k < WIN_SIZE; k++) begin
            win_pixels[k*PIX_W +: PIX_W] = win[k];
        end
    end

endmodule

// File: tb/tb_window_gen_5x5.sv
// Self-checking bench for window_gen_5x5 on an 8x6 frame with a frame-image reference model.
module tb_window_gen_5x5;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 9;
    localparam int WB = 25 * PW;

    typedef enum int {M_RAMP, M_NEG, M_EXT, M_RAND} mode_e;
    typedef struct {
        logic [WB-1:0] pix;
        int            row;
        int            col;
        logic [PW-1:0] centre;
        logic          first;
        mode_e         md;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [PW-1:0] in_pixel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WB-1:0]        win_pixels;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_row;
    logic [2:0]           out_col;
    logic                 frame_done;

    always #5 clk = ~clk;

    window_gen_5x5 #(
        .pixel_int_width (9),
        .pixel_dec_width (0),
        .img_width       (W),
        .img_height      (H),
        .kernel_size     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win_pixels (win_pixels),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    logic [PW-1:0] img [H][W];
    exp_t          q[$];
    int            m_r, m_c, acc_idx, cyc;
    int            total, passed, fails;
    int            fd_pulses, wins, lat_acc, lat_ov;
    mode_e         mode;
    logic [WB-1:0] held;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] gen_pixel();
        case (mode)
            M_RAMP:  return PW'(m_r * 16 + m_c);
            M_NEG:   return PW'(-(m_r * 16 + m_c));
            M_EXT:   return (acc_idx % 2 == 0) ? 9'h100 : 9'h0FF;
            default: return PW'($urandom_range(0, 511));
        endcase
    endfunction

    task automatic model_accept(input logic [PW-1:0] px);
        exp_t e;
        img[m_r][m_c] = px;
        if (m_r >= 4 && m_c >= 4) begin
            for (int k = 0; k < 25; k++) begin
                e.pix[k*PW +: PW] = img[m_r - 4 + k / 5][m_c - 4 + k % 5];
            end
            e.row    = m_r - 2;
            e.col    = m_c - 2;
            e.centre = img[m_r - 2][m_c - 2];
            e.first  = (m_r == 4 && m_c == 4);
            e.md     = mode;
            q.push_back(e);
        end
        acc_idx++;
        if (m_c == W - 1) begin
            m_c = 0;
            m_r = (m_r == H - 1) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_window", 256'(out_valid), 256'(0));
            return;
        end
        e = q.pop_front();
        wins++;
        chk("win_pixels", 256'(win_pixels), 256'(e.pix));
        chk("out_row", 256'(out_row), 256'(e.row));
        chk("out_col", 256'(out_col), 256'(e.col));
        if (e.first && e.md == M_RAMP) begin
            chk("ramp_pixel1", 256'(win_pixels[PW-1:0]), 256'(9'h000));
            chk("ramp_pixel13", 256'(win_pixels[13*PW-1 -: PW]), 256'(9'h022));
            chk("ramp_pixel25", 256'(win_pixels[25*PW-1 -: PW]), 256'(9'h044));
        end
        if (e.first && e.md == M_NEG) begin
            chk("neg_first_row", 256'(out_row), 256'(2));
            chk("neg_first_col", 256'(out_col), 256'(2));
            chk("neg_pixel1", 256'(win_pixels[PW-1:0]), 256'(9'h000));
        end
        if (e.md == M_EXT) begin
            chk("ext_pixel13_centre", 256'(win_pixels[13*PW-1 -: PW]), 256'(e.centre));
        end
    endtask

    task automatic step(input logic v, input logic ord);
        logic [PW-1:0] px;
        logic          acc;
        logic          last;
        px        = gen_pixel();
        in_valid  = v;
        in_pixel  = px;
        out_ready = ord;
        #1;
        acc  = v && in_ready;
        last = (m_r == H - 1 && m_c == W - 1);
        if (out_valid && !ord) chk("in_ready_stall", 256'(in_ready), 256'(0));
        if (out_valid && ord) compare_front();
        if (out_valid && lat_acc >= 0 && lat_ov < 0) lat_ov = cyc;
        if (acc && m_r == 4 && m_c == 4 && lat_acc < 0) lat_acc = cyc;
        if (acc) model_accept(px);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (frame_done) fd_pulses++;
        chk("frame_done", 256'(frame_done), 256'(acc && last));
    endtask

    task automatic run_frame(input mode_e md, input int stall_at, input int npix);
        int start, g, stalls, w0;
        mode   = md;
        start  = acc_idx;
        w0     = wins;
        g      = 0;
        stalls = 0;
        while (acc_idx - start < npix && g < 1000) begin
            if (stall_at >= 0 && out_valid && (wins - w0) == stall_at && stalls < 5) begin
                if (stalls == 0) held = win_pixels;
                step(1'b1, 1'b0);
                stalls++;
                chk("stall_hold", 256'(win_pixels), 256'(held));
            end else begin
                step(1'b1, 1'b1);
            end
            g++;
        end
        chk("frame_accepts", 256'(acc_idx - start), 256'(npix));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 30) begin
            step(1'b0, 1'b1);
            g++;
        end
        chk("drain_empty", 256'(q.size()), 256'(0));
        chk("drain_out_valid", 256'(out_valid), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required $finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, start, g;
        total = 0; passed = 0; fails = 0;
        m_r = 0; m_c = 0; acc_idx = 0; cyc = 0;
        fd_pulses = 0; wins = 0; lat_acc = -1; lat_ov = -1;
        mode = M_RAMP;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_frame_done", 256'(frame_done), 256'(0));
        chk("reset_win_pixels", 256'(win_pixels), 256'(0));
        chk("reset_out_row", 256'(out_row), 256'(0));
        chk("reset_out_col", 256'(out_col), 256'(0));
        chk("reset_in_ready", 256'(in_ready), 256'(1));

        // ramp frame, free-flowing
        w0 = wins; f0 = fd_pulses;
        run_frame(M_RAMP, -1, 48);
        drain();
        chk("ramp_windows", 256'(wins - w0), 256'(8));
        chk("ramp_latency", 256'(lat_ov - lat_acc), 256'(2));
        chk("ramp_frame_done", 256'(fd_pulses - f0), 256'(1));

        // backpressure on window 3, then a negative frame back to back
        w0 = wins; f0 = fd_pulses;
        run_frame(M_RAMP, 2, 48);
        run_frame(M_NEG, -1, 48);
        drain();
        chk("b2b_windows", 256'(wins - w0), 256'(16));
        chk("b2b_frame_done", 256'(fd_pulses - f0), 256'(2));

        // random valid/ready, two frames
        mode = M_RAND;
        w0 = wins; f0 = fd_pulses; start = acc_idx; g = 0;
        while (acc_idx - start < 96 && g < 3000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            g++;
        end
        drain();
        chk("rand_accepts", 256'(acc_idx - start), 256'(96));
        chk("rand_frame_done", 256'(fd_pulses - f0), 256'(2));
        chk("rand_windows", 256'(wins - w0), 256'(16));

        // reset after 20 pixels, then a full ramp frame
        run_frame(M_RAMP, -1, 20);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_frame_done", 256'(frame_done), 256'(0));
        q.delete();
        m_r = 0; m_c = 0;
        w0 = wins; f0 = fd_pulses;
        run_frame(M_RAMP, -1, 48);
        drain();
        chk("midrst_windows", 256'(wins - w0), 256'(8));
        chk("midrst_frame_done_count", 256'(fd_pulses - f0), 256'(1));

        // signed extremes alternating -256 / 255
        w0 = wins;
        run_frame(M_EXT, -1, 48);
        drain();
        chk("ext_windows", 256'(wins - w0), 256'(8));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
